alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Issue controller that sits in front of the TotalALU datapath and sequences one operation at a time from a valid/ready request port. It holds the function code and operands stable for as long as each operation class needs: a fixed short window for AND/OR/ADD/SUB/SLT/SLL, the full iterative window for MULTU plus a HiLo capture cycle, and a read window for MFHI/MFLO. It captures the datapath result into a response register and presents it through a valid/ready response port.

## Interface
- `MUL_CYCLES`, default 32: cycles that `Signal`=MULTU is held before HiLo capture.
- `ALU_LAT`, default 1: cycles from first drive of `Signal` to valid `Output` for non-multiply ops; legal range 1..3.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept a request; high only in IDLE.
- `req_op` input 6: function code.
- `req_a` input 32: operand A.
- `req_b` input 32: operand B.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer accepts the response.
- `resp_data` output 32: result.
- `resp_err` output 1: illegal op or HI/LO read before any MULTU. Forced 0 when `ALU_SEQ_TRAP_EN` is undefined.
- `alu_signal` output 6: drives datapath `Signal`.
- `alu_a` output 32: drives datapath `dataA`.
- `alu_b` output 32: drives datapath `dataB`.
- `alu_out` input 32: datapath `Output`.
- `busy` output 1: high in every state other than IDLE.

## Operation
- Function codes: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SLL 0, MULTU 25, MFHI 16, MFLO 18. NOP code 63 is driven whenever no op is in flight.
- States:
  - **IDLE**: `req_ready`=1. On `req_valid`, register op and operands, then branch: MULTU goes to MUL, all other ops go to EXEC.
  - **EXEC**: `alu_signal`/`alu_a`/`alu_b` are held for `ALU_LAT` cycles. In the last cycle, `alu_out` is sampled into `resp_data`. Next state is RESP.
  - **MUL**: `alu_signal`=MULTU is held. A counter runs from 0 to `MUL_CYCLES`-1. At terminal count the next state is HILO.
  - **HILO**: `alu_signal`=NOP for exactly 1 cycle while HiLo captures. `hilo_valid` is set. `resp_data`=0. Next state is RESP.
  - **RESP**: `resp_valid`=1, and `resp_data`/`resp_err` are stable. On `resp_ready`, go to IDLE.
- Operand and op registers change only on IDLE acceptance. Outputs to the datapath never glitch mid-op.
- `hilo_valid` is cleared only by reset. A MULTU that is aborted by reset does not set it.
- Reset mid-operation: every state returns to IDLE immediately. The counter and `hilo_valid` clear, and the in-flight op is discarded with no response.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_err`=0, `alu_signal`=63, `alu_a`=0, `alu_b`=0, `busy`=0.
- Acceptance at edge T:
  - EXEC ops: `resp_valid` at T+`ALU_LAT`+1.
  - MULTU: `resp_valid` at T+`MUL_CYCLES`+2.
  - Trapped ops: `resp_valid` at T+1.
- Back-to-back: at least 1 IDLE cycle between ops. Sustained ALU throughput is one op per `ALU_LAT`+2 cycles with `resp_ready` tied high.
- `resp_valid` is held until a handshake completes. Backpressure stalls in RESP indefinitely.
- `req_valid` while not ready is ignored. The request must be held by the requester.

## Configuration
- `ALU_SEQ_TRAP_EN` defined:
  - An op not in the code list, or MFHI/MFLO with `hilo_valid`=0, goes IDLE→RESP directly with `resp_err`=1 and `resp_data`=0.
  - The datapath is never driven for these ops.
- Undefined:
  - Unknown codes take the EXEC path, forwarding `alu_out` as returned.
  - MFHI/MFLO before any MULTU return `alu_out`, which is 0 after reset.
  - `resp_err` is constant 0.

## Structure
- Shared package `alu_pkg`: function-code constants (AND…MFLO, NOP), the state enum, and the op-class decode function (ALU/MUL/HILO/ILLEGAL).
- One natural sub-module, `alu_seq_cnt`: a loadable down-counter with a terminal-count flag, used for both the `ALU_LAT` window and the `MUL_CYCLES` window.

## Test plan
- ADD: A=5, B=7 → `resp_data`=12 at T+`ALU_LAT`+1; `alu_signal`=32 during EXEC, 63 otherwise.
- MULTU: A=0xFFFFFFFF, B=2. `resp_valid` at T+34 with data 0. Then MFHI→1 and MFLO→0xFFFFFFFE.
- With `ALU_SEQ_TRAP_EN`: MFLO right after reset, and op 5, each give `resp_err`=1 and data 0 at T+1.
- Backpressure: SLT with A=-1, B=1 and `resp_ready` low for 10 cycles. `resp_data`=1 is held stable, `req_ready`=0 throughout, and a second request is accepted only after the handshake.
- Reset asserted at cycle 15 of a MULTU: outputs match reset values in the same cycle, and a following MFHI under `ALU_SEQ_TRAP_EN` gives `resp_err`=1.
- SLL: A=1, B=4 → 16; back-to-back AND then OR with `resp_ready` high complete one op per `ALU_LAT`+2 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the TotalALU issue controller: function codes,
// controller states and the op-class decode.
package alu_pkg;

  localparam logic [5:0] FnAnd   = 6'd36;
  localparam logic [5:0] FnOr    = 6'd37;
  localparam logic [5:0] FnAdd   = 6'd32;
  localparam logic [5:0] FnSub   = 6'd34;
  localparam logic [5:0] FnSlt   = 6'd42;
  localparam logic [5:0] FnSll   = 6'd0;
  localparam logic [5:0] FnMultu = 6'd25;
  localparam logic [5:0] FnMfhi  = 6'd16;
  localparam logic [5:0] FnMflo  = 6'd18;
  localparam logic [5:0] FnNop   = 6'd63;

  typedef enum logic [2:0] {
    Idle,
    Exec,
    Mul,
    HiLo,
    Resp
  } stateT;

  typedef enum logic [1:0] {
    ClassAlu,
    ClassMul,
    ClassHilo,
    ClassIllegal
  } opClassT;

  // Sorts a function code into the window it needs on the datapath.
  function automatic opClassT decodeOp(input logic [5:0] op);
    opClassT opClass;
    case (op)
      FnAnd, FnOr, FnAdd, FnSub, FnSlt, FnSll: opClass = ClassAlu;
      FnMultu:                                 opClass = ClassMul;
      FnMfhi, FnMflo:                          opClass = ClassHilo;
      default:                                 opClass = ClassIllegal;
    endcase
    return opClass;
  endfunction

endpackage

// File: rtl/alu_seq_cnt.sv
// Loadable down-counter with terminal-count flag; times both the short ALU
// window and the multiply window.
module alu_seq_cnt #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] loadVal,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Load wins over counting; the count parks at zero until reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Issue controller in front of the TotalALU datapath: one op at a time from a
// valid/ready request port to a valid/ready response port. Optional trapping
// of illegal ops and early HI/LO reads is enabled by defining ALU_SEQ_TRAP_EN.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int ALU_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  output logic        busy
);

  localparam int CntMax = (MUL_CYCLES > ALU_LAT) ? MUL_CYCLES : ALU_LAT;
  localparam int CntW   = $clog2(CntMax + 1);

  stateT             state;
  stateT             nextState;
  opClassT           reqClass;
  logic              accept;
  logic              trapReq;
  logic              cntLoad;
  logic              cntEn;
  logic              cntTc;
  logic [CntW-1:0]   cntLoadVal;
  logic [5:0]        opReg;
  logic [31:0]       aReg;
  logic [31:0]       bReg;
  logic [31:0]       respDataReg;

  assign reqClass = decodeOp(req_op);
  assign accept   = req_valid && (state == Idle);

`ifdef ALU_SEQ_TRAP_EN
  logic hiloValid;
  logic respErrReg;

  assign trapReq = (reqClass == ClassIllegal) ||
                   ((reqClass == ClassHilo) && !hiloValid);

  // HI/LO become readable once a multiply has reached its capture cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiloValid <= 1'b0;
    end else if (state == HiLo) begin
      hiloValid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      respErrReg <= 1'b0;
    end else if (accept) begin
      respErrReg <= trapReq;
    end
  end

  assign resp_err = respErrReg;
`else
  assign trapReq  = 1'b0;
  assign resp_err = 1'b0;
`endif

  // One counter serves both windows; it is reloaded on every acceptance.
  assign cntLoad    = accept;
  assign cntEn      = (state == Exec) || (state == Mul);
  assign cntLoadVal = (reqClass == ClassMul) ? CntW'(MUL_CYCLES - 1)
                                             : CntW'(ALU_LAT - 1);

  alu_seq_cnt #(
    .WIDTH(CntW)
  ) uCnt (
    .clk    (clk),
    .reset  (reset),
    .load   (cntLoad),
    .en     (cntEn),
    .loadVal(cntLoadVal),
    .tc     (cntTc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= Idle;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      Idle: begin
        if (req_valid) begin
          if (trapReq) begin
            nextState = Resp;
          end else if (reqClass == ClassMul) begin
            nextState = Mul;
          end else begin
            nextState = Exec;
          end
        end
      end
      Exec: if (cntTc) nextState = Resp;
      Mul:  if (cntTc) nextState = HiLo;
      HiLo: nextState = Resp;
      Resp: if (resp_ready) nextState = Idle;
      default: nextState = Idle;
    endcase
  end

  // Op and operands are frozen from acceptance until the next acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opReg <= FnNop;
      aReg  <= '0;
      bReg  <= '0;
    end else if (accept) begin
      opReg <= req_op;
      aReg  <= req_a;
      bReg  <= req_b;
    end
  end

  // The multiply leaves its result in HiLo, so its response carries zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      respDataReg <= '0;
    end else if (accept) begin
      respDataReg <= '0;
    end else if ((state == Exec) && cntTc) begin
      respDataReg <= alu_out;
    end else if (state == HiLo) begin
      respDataReg <= '0;
    end
  end

  // All outputs are decoded from registers only, so they cannot glitch.
  always_comb begin
    req_ready  = (state == Idle);
    busy       = (state != Idle);
    resp_valid = (state == Resp);
    resp_data  = respDataReg;
    alu_signal = FnNop;
    alu_a      = '0;
    alu_b      = '0;
    if ((state == Exec) || (state == Mul)) begin
      alu_signal = opReg;
      alu_a      = aReg;
      alu_b      = bReg;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural TotalALU stand-in;
// expectations follow ALU_SEQ_TRAP_EN when it is defined.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [5:0]  alu_signal;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        busy;

  logic [31:0] hiReg;
  logic [31:0] loReg;

  int vectorCount = 0;
  int missCount   = 0;

  alu_seq_ctrl #(
    .MUL_CYCLES(32),
    .ALU_LAT   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .alu_signal(alu_signal),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in datapath: combinational result, HiLo written while MULTU is held.
  always_comb begin
    alu_out = 32'd0;
    case (alu_signal)
      6'd36: alu_out = alu_a & alu_b;
      6'd37: alu_out = alu_a | alu_b;
      6'd32: alu_out = alu_a + alu_b;
      6'd34: alu_out = alu_a - alu_b;
      6'd42: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      6'd0:  alu_out = alu_a << alu_b[4:0];
      6'd16: alu_out = hiReg;
      6'd18: alu_out = loReg;
      default: alu_out = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiReg <= 32'd0;
      loReg <= 32'd0;
    end else if (alu_signal == 6'd25) begin
      {hiReg, loReg} <= 64'(alu_a) * 64'(alu_b);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitResp(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!resp_valid && cycles < 200);
  endtask

  task automatic applyStimulus(input string tag, input logic [5:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expData, input logic expErr,
                               input int expLat, output logic [5:0] firstSig);
    int cycles;
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cycles   = 0;
    firstSig = 6'd0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) firstSig = alu_signal;
    end while (!resp_valid && cycles < 200);
    checkOutput({tag, "_lat"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, "_data"}, resp_data, expData);
    checkOutput({tag, "_err"}, {31'd0, resp_err}, {31'd0, expErr});
    checkOutput({tag, "_respSig"}, {26'd0, alu_signal}, 32'd63);
    @(posedge clk);
  endtask

  initial begin
    logic [5:0] sig;
    int         cycles;
    logic       trapOn;
    int         trapLat;
    logic [5:0] mulSig;

`ifdef ALU_SEQ_TRAP_EN
    trapOn  = 1'b1;
    trapLat = 1;
`else
    trapOn  = 1'b0;
    trapLat = 2;
`endif

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 6'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_reqReady", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_respValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_respData", resp_data, 32'd0);
    checkOutput("rst_respErr", {31'd0, resp_err}, 32'd0);
    checkOutput("rst_aluSignal", {26'd0, alu_signal}, 32'd63);
    checkOutput("rst_aluA", alu_a, 32'd0);
    checkOutput("rst_aluB", alu_b, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Early HI/LO read and an unknown code: trapped or forwarded.
    applyStimulus("mfloEarly", 6'd18, 32'd0, 32'd0, 32'd0, trapOn, trapLat, sig);
    checkOutput("mfloEarly_sig", {26'd0, sig}, trapOn ? 32'd63 : 32'd18);
    applyStimulus("op5", 6'd5, 32'd3, 32'd4, 32'd0, trapOn, trapLat, sig);

    applyStimulus("add", 6'd32, 32'd5, 32'd7, 32'd12, 1'b0, 2, sig);
    checkOutput("add_execSig", {26'd0, sig}, 32'd32);

    applyStimulus("multu", 6'd25, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 34, sig);
    checkOutput("multu_sig", {26'd0, sig}, 32'd25);
    applyStimulus("mfhi", 6'd16, 32'd0, 32'd0, 32'd1, 1'b0, 2, sig);
    applyStimulus("mflo", 6'd18, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0, 2, sig);

    // Backpressure on an SLT while a second request waits.
    @(negedge clk);
    resp_ready = 1'b0;
    req_op     = 6'd42;
    req_a      = 32'hFFFF_FFFF;
    req_b      = 32'd1;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    waitResp(cycles);
    checkOutput("slt_lat", 32'(cycles), 32'd2);
    checkOutput("slt_data", resp_data, 32'd1);
    req_op    = 6'd32;
    req_a     = 32'd2;
    req_b     = 32'd3;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", {31'd0, resp_valid}, 32'd1);
      checkOutput("bp_data", resp_data, 32'd1);
      checkOutput("bp_reqReady", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 checkOutput("bp_idleAfter", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    waitResp(cycles);
    checkOutput("bp2_lat", 32'(cycles), 32'd2);
    checkOutput("bp2_data", resp_data, 32'd5);
    @(posedge clk);

    applyStimulus("sll", 6'd0, 32'd1, 32'd4, 32'd16, 1'b0, 2, sig);

    // Back-to-back AND then OR with the request held high.
    @(negedge clk);
    req_op    = 6'd36;
    req_a     = 32'h0000_F0F0;
    req_b     = 32'h0000_FF00;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_op = 6'd37;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (resp_valid) checkOutput("b2b_andData", resp_data, 32'h0000_F000);
    end while (!req_ready && cycles < 50);
    checkOutput("b2b_interval", 32'(cycles), 32'd3);
    @(posedge clk);
    #1 req_valid = 1'b0;
    waitResp(cycles);
    checkOutput("b2b_orLat", 32'(cycles), 32'd2);
    checkOutput("b2b_orData", resp_data, 32'h0000_FFF0);
    @(posedge clk);

    // Reset during cycle 15 of a multiply.
    @(negedge clk);
    req_op    = 6'd25;
    req_a     = 32'd7;
    req_b     = 32'd9;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    mulSig = 6'd0;
    repeat (15) begin
      @(negedge clk);
      mulSig = alu_signal;
    end
    checkOutput("abort_mulSig", {26'd0, mulSig}, 32'd25);
    reset = 1'b1;
    #1;
    checkOutput("abort_reqReady", {31'd0, req_ready}, 32'd1);
    checkOutput("abort_respValid", {31'd0, resp_valid}, 32'd0);
    checkOutput("abort_respData", resp_data, 32'd0);
    checkOutput("abort_aluSignal", {26'd0, alu_signal}, 32'd63);
    checkOutput("abort_aluA", alu_a, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("mfhiAbort", 6'd16, 32'd0, 32'd0, 32'd0, trapOn, trapLat, sig);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
